// File: rtl/seq_loader.sv
// seq_loader: ASCII nucleotide stream to solver seq1/seq2 loader.
// Ports: clk, rst(async low), in_* handshake, seq1/seq2, solver ctl, err status.
//
// seq1/seq2 are packed: element i sits at bits [2i+1:2i].
// Base encoding: A=0, C=1, G=2, T=3.
module seq_loader #(
  parameter int len1        = 5,
  parameter int len2        = 5,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [2*len1-1:0] seq1,
  output logic [2*len2-1:0] seq2,
  output logic              solver_rst,
  input  logic              solver_finished,
  output logic              busy,
  output logic              job_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [7:0]        err_count
);

  localparam int MAXL = (len1 > len2) ? len1 : len2;
  localparam int IW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [IW-1:0] L1M = IW'(len1 - 1);
  localparam logic [IW-1:0] L2M = IW'(len2 - 1);
  localparam logic [31:0]   TO  = 32'(RUN_TIMEOUT);

  typedef enum logic [1:0] {
    LOAD1, LOAD2, RUN, DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            rdy_q;
  logic            srst_q, srst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [7:0]      ecnt_q, ecnt_d;
  logic [1:0]      s1_q [len1];
  logic [1:0]      s2_q [len2];

  logic            xfer;
  logic            legal;
  logic [1:0]      base;
  logic            we1, we2;
  logic            abort, drain;
  logic [1:0]      acode;

  always_comb begin
    legal = 1'b1;
    base  = 2'd0;
    unique case (in_data)
      8'h41, 8'h61: base = 2'd0;
      8'h43, 8'h63: base = 2'd1;
      8'h47, 8'h67: base = 2'd2;
      8'h54, 8'h74: base = 2'd3;
      default:      legal = 1'b0;
    endcase
  end

  // rdy_q keeps in_ready low until the first edge after reset.
  assign in_ready = rdy_q & (state_q != RUN);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    srst_d  = srst_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    ecnt_d  = ecnt_q;
    we1     = 1'b0;
    we2     = 1'b0;
    abort   = 1'b0;
    drain   = 1'b0;
    acode   = 2'd0;
    unique case (state_q)
      LOAD1: begin
        if (xfer) begin
          if (!legal) begin
            abort = 1'b1;
            acode = 2'd1;
          end else if (in_last) begin
            abort = 1'b1;
            acode = 2'd2;
          end else begin
            we1 = 1'b1;
            if (idx_q == L1M) begin
              idx_d   = '0;
              state_d = LOAD2;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      LOAD2: begin
        if (xfer) begin
          if (!legal) begin
            abort = 1'b1;
            acode = 2'd1;
          end else if (idx_q == L2M) begin
            if (in_last) begin
              we2     = 1'b1;
              state_d = RUN;
              srst_d  = 1'b0;
              busy_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              abort = 1'b1;
              acode = 2'd2;
              drain = 1'b1;
            end
          end else if (in_last) begin
            abort = 1'b1;
            acode = 2'd2;
          end else begin
            we2   = 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        // finished is ignored for two cycles: it may still be the
        // previous job's flag until the solver sees its reset drop.
        if (cnt_q >= 32'd2 && solver_finished) begin
          done_d  = 1'b1;
          srst_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = LOAD1;
        end else if (RUN_TIMEOUT != 0 && cnt_q == TO) begin
          abort = 1'b1;
          acode = 2'd3;
        end
      end
      DRAIN: begin
        if (xfer && in_last) begin
          state_d = LOAD1;
        end
      end
      default: state_d = LOAD1;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      code_d  = acode;
      ecnt_d  = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
      srst_d  = 1'b1;
      busy_d  = 1'b0;
      idx_d   = '0;
      state_d = drain ? DRAIN : LOAD1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD1;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      srst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      ecnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      srst_q  <= srst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < len1; i++) s1_q[i] <= 2'd0;
      for (int i = 0; i < len2; i++) s2_q[i] <= 2'd0;
    end else begin
      if (we1) s1_q[idx_q] <= base;
      if (we2) s2_q[idx_q] <= base;
    end
  end

  always_comb begin
    seq1 = '0;
    seq2 = '0;
    for (int i = 0; i < len1; i++) seq1[2*i +: 2] = s1_q[i];
    for (int i = 0; i < len2; i++) seq2[2*i +: 2] = s2_q[i];
  end

  assign solver_rst = srst_q;
  assign busy       = busy_q;
  assign job_done   = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign err_count  = ecnt_q;

endmodule

// File: doc/seq_loader.md
Name: seq_loader

Overview:
- Upstream feeder for the systolic short solver.
- Accepts an 8-bit ASCII nucleotide byte stream over a valid/ready handshake and decodes it into the solver's seq1/seq2 dna_base arrays.
- Holds the solver in reset while loading, then releases it to run. Waits for the solver's finished flag before accepting the next job.
- Rejects malformed jobs (illegal character, wrong length) without ever releasing the solver.

Parameters:
- len1, 5: seq1 length; must equal the solver's len1.
- len2, 5: seq2 length; must equal the solver's len2.
- RUN_TIMEOUT, 4096: maximum cycles in RUN before a forced abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  marks the final byte of a job.
- in_ready  out  1  loader accepts in_data this cycle.
- seq1  out  dna_base[len1]  decoded first sequence; element 0 is the first byte received.
- seq2  out  dna_base[len2]  decoded second sequence.
- solver_rst  out  1  active-high reset to the solver.
- solver_finished  in  1  solver's finished output.
- busy  out  1  solver is running.
- job_done  out  1  one-cycle pulse when a job completes.
- err  out  1  one-cycle pulse when a job is aborted.
- err_code  out  2  reason for the last abort: 0 none, 1 illegal char, 2 length, 3 timeout.
- err_count  out  8  saturating count of aborted jobs.

Behaviour:
- Reset (rst low, asynchronous): state LOAD1, idx=0, solver_rst=1, in_ready=0, busy=0, job_done=0, err=0, err_code=0, err_count=0, all seq1/seq2 elements = A. in_ready rises on the first clock edge after rst releases.
- Handshake: a transfer occurs when in_valid & in_ready at a rising edge. in_ready is combinational from state only (high in LOAD1/LOAD2), never from in_valid.
- Decode: 'A'/'a'→A, 'C'/'c'→C, 'G'/'g'→G, 'T'/'t'→T. Any other byte is illegal.
- LOAD1: each accepted byte writes seq1[idx], then idx++.
  - After byte len1-1 is accepted: idx←0, go to LOAD2.
- LOAD2: each accepted byte writes seq2[idx], then idx++.
  - After byte len2-1 is accepted with in_last=1: go to RUN.
- RUN:
  - On the cycle entering RUN, solver_rst←0 and busy←1, registered.
  - in_ready=0; seq1/seq2 are frozen.
  - A run-cycle counter starts at 0.
  - solver_finished is sampled only when the counter ≥ 2, which masks stale finished from the previous job.
- Completion: when solver_finished=1 in RUN, job_done pulses for one cycle, solver_rst←1, busy←0, idx←0, go to LOAD1.
- Abort conditions (checked on the transferring beat, priority illegal > length):
  - illegal char in LOAD1/LOAD2 → code 1;
  - in_last=1 on any beat other than byte len2-1 of seq2 → code 2;
  - in_last=0 on byte len2-1 of seq2 → code 2;
  - counter reaching RUN_TIMEOUT in RUN → code 3.
- On abort:
  - err pulses for one cycle; err_code is latched; err_count += 1, saturating at 255.
  - solver_rst←1, busy←0, idx←0, go to LOAD1.
  - The offending byte is consumed and discarded. Previously written seq entries are not cleared.
- DRAIN sub-rule: after a code-2 abort caused by a missing in_last, bytes are discarded, with in_ready=1 and nothing written, up to and including the next beat carrying in_last. Then the loader resumes in LOAD1.
- Simultaneous events: a solver_finished and timeout in the same cycle count as completion.
- err_code holds its value until the next abort. It is cleared only by rst.
- Mid-operation reset: rst low during any state returns immediately to the reset values. solver_rst asserts asynchronously.
- Throughput: one byte per cycle. Latency from the last accepted byte to solver_rst falling is 1 cycle.

Test Plan:
- Reset, then stream "CAGTA" then "GCATA" (last on final 'A'), back-to-back valid → seq1={C,A,G,T,A}, seq2={G,C,A,T,A}; solver_rst falls 1 cycle after the 10th beat; busy=1.
- Drive solver_finished=1 on cycle 5 of RUN → job_done pulses once; in_ready=1 next cycle; solver_rst=1; a second job loads correctly.
- Send "CAGXA…" → err pulse on the 'X' beat, err_code=1, err_count=1, solver_rst stays 1, state LOAD1.
- Assert in_last on byte 7 → err_code=2. Then omit in_last on byte 10 of a new job → err_code=2, following bytes discarded until in_last, then a clean job succeeds.
- RUN_TIMEOUT=16, solver_finished held 0 → err at run cycle 16, err_code=3. Then hold solver_finished=1 through reload and confirm no false job_done in RUN cycles 0–1.
- Pull rst low mid-LOAD2 and mid-RUN → all outputs return to reset values asynchronously. Also force 256 aborts → err_count saturates at 255.
